// File: rtl/serial_mag_compare.sv
// serial_mag_compare: bit-serial MSB-first magnitude comparator.
// Folds per-bit decisions over time and holds registered gt/eq/lt
// results until the next compare completes.
module serial_mag_compare #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_run_gt;
  logic          r_run_eq;
  logic          r_run_lt;

  logic          w_nxt_gt;
  logic          w_nxt_eq;
  logic          w_nxt_lt;
  logic          w_last;

  // Decision for the current bit pair; only the first differing bit
  // (while still equal) can set gt or lt, so the MSB dominates.
  always_comb begin
    w_nxt_gt = r_run_gt | (r_run_eq & a_bit & ~b_bit);
    w_nxt_lt = r_run_lt | (r_run_eq & ~a_bit & b_bit);
    w_nxt_eq = r_run_eq & ~(a_bit ^ b_bit);
    w_last   = (r_cnt == LAST_CNT);
  end

  // Control FSM with registered busy/done and committed result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_run_gt <= 1'b0;
      r_run_eq <= 1'b1;
      r_run_lt <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            busy     <= 1'b1;
            r_cnt    <= '0;
            r_run_gt <= 1'b0;
            r_run_eq <= 1'b1;
            r_run_lt <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Cancel without touching the previously committed result.
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (bit_valid) begin
            r_run_gt <= w_nxt_gt;
            r_run_eq <= w_nxt_eq;
            r_run_lt <= w_nxt_lt;
            if (w_last) begin
              // Counter is left at its final value so it never wraps.
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              gt      <= w_nxt_gt;
              eq      <= w_nxt_eq;
              lt      <= w_nxt_lt;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            r_state  <= S_RUN;
            busy     <= 1'b1;
            r_cnt    <= '0;
            r_run_gt <= 1'b0;
            r_run_eq <= 1'b1;
            r_run_lt <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Testbench for serial_mag_compare (WIDTH=8): table vectors, randomized
// compares against an integer reference, and hand-written corner sequences.
module tb_serial_mag_compare;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n, start, abort, bit_valid, a_bit, b_bit;
  logic busy, done, gt, eq, lt;

  int n_tests = 0;
  int n_fail  = 0;

  serial_mag_compare #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] gapc;  // 2-bit idle count after each streamed bit i
    logic        egt;
    logic        eeq;
    logic        elt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full compare from IDLE or DONE; checks done lands exactly on the
  // last accepted bit and nowhere earlier.
  task automatic do_cmp(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] gapc, input logic egt, input logic eeq,
                        input logic elt);
    logic early;
    early = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, " busy_after_start"}, busy, 1'b1);
    for (int i = 0; i < W; i++) begin
      bit_valid = 1'b1;
      a_bit     = a[W-1-i];
      b_bit     = b[W-1-i];
      tick();
      bit_valid = 1'b0;
      if (i < W - 1) begin
        if (done || !busy) early = 1'b1;
        for (int g = 0; g < int'(gapc[2*i +: 2]); g++) begin
          tick();
          if (done || !busy) early = 1'b1;
        end
      end
    end
    check({nm, " no_early_done"}, early, 1'b0);
    check({nm, " done"}, done, 1'b1);
    check({nm, " busy_low"}, busy, 1'b0);
    check({nm, " gt"}, gt, egt);
    check({nm, " eq"}, eq, eeq);
    check({nm, " lt"}, lt, elt);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] rg;

    vecs[0] = '{a: 8'hA5, b: 8'hA5, gapc: 16'h0000, egt: 1'b0, eeq: 1'b1, elt: 1'b0};
    vecs[1] = '{a: 8'h80, b: 8'h7F, gapc: 16'h0000, egt: 1'b1, eeq: 1'b0, elt: 1'b0};
    vecs[2] = '{a: 8'h3C, b: 8'h3D, gapc: 16'h0000, egt: 1'b0, eeq: 1'b0, elt: 1'b1};
    vecs[3] = '{a: 8'h5A, b: 8'h59, gapc: 16'h1020, egt: 1'b1, eeq: 1'b0, elt: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'hFF, gapc: 16'h0000, egt: 1'b0, eeq: 1'b0, elt: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, gapc: 16'h0404, egt: 1'b0, eeq: 1'b1, elt: 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (3) tick();
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst flags", {gt, eq, lt}, 3'b000);
    rst_n = 1'b1;
    tick();
    check("post_rst flags", {gt, eq, lt}, 3'b000);

    // Table vectors, with an idle cycle in between to check done drops.
    foreach (vecs[k]) begin
      do_cmp($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].gapc,
             vecs[k].egt, vecs[k].eeq, vecs[k].elt);
      tick();
      check($sformatf("vec%0d done_pulse", k), done, 1'b0);
      check($sformatf("vec%0d hold", k), {gt, eq, lt},
            {vecs[k].egt, vecs[k].eeq, vecs[k].elt});
    end

    // Back-to-back: start issued in the DONE cycle of the previous compare.
    do_cmp("b2b_first", 8'h3C, 8'h3D, 16'h0000, 1'b0, 1'b0, 1'b1);
    do_cmp("b2b_second", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();

    // Abort together with start after 4 bits: previous result must stay.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;  // 0xF0 vs 0x0F
      tick();
    end
    abort = 1'b1; start = 1'b1; bit_valid = 1'b0;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort flags", {gt, eq, lt}, 3'b010);
    tick();
    check("abort idle busy", busy, 1'b0);
    check("abort idle done", done, 1'b0);
    do_cmp("after_abort", 8'hF0, 8'h0F, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();

    // Abort coinciding with the final beat: no commit, no done.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < W - 1; i++) begin
      bit_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1;
      tick();
    end
    bit_valid = 1'b1; abort = 1'b1;
    tick();
    bit_valid = 1'b0; abort = 1'b0;
    check("abort_last done", done, 1'b0);
    check("abort_last busy", busy, 1'b0);
    check("abort_last flags", {gt, eq, lt}, 3'b100);
    tick();

    // Reset mid-RUN after a completed gt compare.
    do_cmp("pre_rst", 8'h80, 8'h7F, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    bit_valid = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst flags", {gt, eq, lt}, 3'b000);
    start = 1'b1;
    tick();
    check("rst_start_ignored", busy, 1'b0);
    start = 1'b0; rst_n = 1'b1;
    tick();
    do_cmp("post_midrst", 8'h3C, 8'h3D, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();

    // Randomized compares against an arithmetic reference.
    for (int r = 0; r < 30; r++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      rg = 16'($urandom) & 16'h5555;
      do_cmp($sformatf("rnd%0d_%0h_%0h", r, ra, rb), ra, rb, rg,
             ra > rb, ra == rb, ra < rb);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
